uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states and character-length encodings.
// The PARITY state exists only when UART_TX_FIFO_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_FIFO_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} tx_state_e;
`endif

    localparam logic [1:0] LEN_5 = 2'd0;
    localparam logic [1:0] LEN_6 = 2'd1;
    localparam logic [1:0] LEN_7 = 2'd2;
    localparam logic [1:0] LEN_8 = 2'd3;

    function automatic logic [3:0] lenToBits(input logic [1:0] len);
        case (len)
            LEN_5:   return 4'd5;
            LEN_6:   return 4'd6;
            LEN_7:   return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a one-cycle overflow pulse.
// A write while full is dropped even if a read happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wrOk, rdOk;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rdPtr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrOk       = wr_en_i && !full_o;
        rdOk       = rd_en_i && !empty_o;
        overflow_d = wr_en_i && full_o;
        wrPtr_d    = wrOk ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d    = rdOk ? rdPtr_q + 1'b1 : rdPtr_q;
        case ({wrOk, rdOk})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrOk) mem_q[wrPtr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with programmable divisor, length, parity and stop bits.
// Parity support is compiled in only when UART_TX_FIFO_PARITY_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_n,
    input  logic [DIV_W-1:0]              i_ClksPerBit,
    input  logic [1:0]                    i_DataBits,
    input  logic                          i_ParityEn,
    input  logic                          i_ParityOdd,
    input  logic                          i_TwoStop,
    input  logic                          i_WrEn,
    input  logic [7:0]                    i_WrData,
    output logic                          o_Full,
    output logic                          o_Empty,
    output logic                          o_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Overflow,
    output logic                          o_UART_TX
);
    tx_state_e        state_q;
    logic [DIV_W-1:0] timer_q, cpb_q;
    logic [2:0]       bitCnt_q;
    logic [3:0]       nBits_q;
    logic [7:0]       shift_q;
    logic             twoStop_q, tx_q;
    logic [7:0]       fifoData, loadData;
    logic [3:0]       loadBits;
    logic             fifoEmpty, pop, bitDone, lastStop;

`ifdef UART_TX_FIFO_PARITY_EN
    logic             parEn_q, parBit_q;
`else
    logic             unusedParity;
    assign unusedParity = i_ParityEn ^ i_ParityOdd;
`endif

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (i_Clk),
        .rst_ni     (i_Rst_n),
        .wr_en_i    (i_WrEn),
        .wr_data_i  (i_WrData),
        .rd_en_i    (pop),
        .rd_data_o  (fifoData),
        .full_o     (o_Full),
        .empty_o    (fifoEmpty),
        .count_o    (o_Count),
        .overflow_o (o_Overflow)
    );

    assign o_Empty   = fifoEmpty;
    assign o_Busy    = (state_q != IDLE);
    assign o_UART_TX = tx_q;

    // A divisor of zero behaves as one, so the bit ends every cycle.
    always_comb begin
        loadBits = lenToBits(i_DataBits);
        loadData = fifoData & (8'hFF >> (4'd8 - loadBits));
        bitDone  = (cpb_q == '0) || (timer_q == cpb_q - 1'b1);
        lastStop = (state_q == STOP2) || ((state_q == STOP1) && !twoStop_q);
        pop      = !fifoEmpty && ((state_q == IDLE) || (lastStop && bitDone));
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            timer_q   <= '0;
            cpb_q     <= '0;
            bitCnt_q  <= '0;
            nBits_q   <= '0;
            shift_q   <= '0;
            twoStop_q <= 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
            parEn_q   <= 1'b0;
            parBit_q  <= 1'b0;
`endif
        end else if (pop) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            timer_q   <= '0;
            cpb_q     <= i_ClksPerBit;
            bitCnt_q  <= '0;
            nBits_q   <= loadBits;
            shift_q   <= loadData;
            twoStop_q <= i_TwoStop;
`ifdef UART_TX_FIFO_PARITY_EN
            parEn_q   <= i_ParityEn;
            parBit_q  <= (^loadData) ^ i_ParityOdd;
`endif
        end else if (state_q == IDLE) begin
            tx_q <= 1'b1;
        end else if (!bitDone) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                end
                DATA: begin
                    if (bitCnt_q == 3'(nBits_q - 4'd1)) begin
`ifdef UART_TX_FIFO_PARITY_EN
                        if (parEn_q) begin
                            state_q <= PARITY;
                            tx_q    <= parBit_q;
                        end else begin
                            state_q <= STOP1;
                            tx_q    <= 1'b1;
                        end
`else
                        state_q <= STOP1;
                        tx_q    <= 1'b1;
`endif
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                        tx_q     <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
`ifdef UART_TX_FIFO_PARITY_EN
                PARITY: begin
                    state_q <= STOP1;
                    tx_q    <= 1'b1;
                end
`endif
                STOP1: begin
                    state_q <= twoStop_q ? STOP2 : IDLE;
                    tx_q    <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
